// File: rtl/aux_irq_intake_pkg.sv
// Shared constants and helpers for the external event intake block.
package aux_irq_intake_pkg;

  localparam int unsigned AUX_CLK_HZ           = 32'd100_000_000;
  // 10 ms worth of board-clock cycles.
  localparam int unsigned AUX_DEBOUNCE_DEFAULT = AUX_CLK_HZ / 32'd100;
  localparam int unsigned AUX_IRQ_ID_BIT       = 32'd2;
  localparam int unsigned AUX_MAX_CHANNELS     = 32'd8;

  typedef logic [AUX_MAX_CHANNELS-1:0] chan_vec_t;

  // Lowest set index of a channel vector; 0 when empty.
  function automatic logic [2:0] first_set(input chan_vec_t vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = AUX_MAX_CHANNELS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/aux_irq_intake_if.sv
// Request/acknowledge handshake between the event intake and the core.
interface aux_irq_if #(
  parameter int unsigned IdBit = 2
);
  logic             ack;
  logic             irq_valid;
  logic [IdBit-1:0] irq_id;

  // Intake side presents requests, core side acknowledges.
  modport master (input ack, output irq_valid, output irq_id);
  modport slave  (output ack, input irq_valid, input irq_id);
endinterface

// File: rtl/aux_irq_intake_debounce.sv
// Single-channel 2-FF synchroniser plus counter debouncer with rise pulse.
module aux_debounce #(
  parameter int unsigned DebounceCnt = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = (DebounceCnt > 1) ? $clog2(DebounceCnt) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCnt - 1);

  logic            s1_r;
  logic            s2_r;
  logic            level_r;
  logic [CntW-1:0] cnt_r;
  logic            accept_s;

  // Level change is accepted on the edge where the counter reaches its last value.
  always_comb begin
    accept_s = (s2_r != level_r) && (cnt_r == CntLast);
    rise     = accept_s & s2_r;
  end

  // Synchroniser, stable-cycle counter and accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= {CntW{1'b0}};
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
      if (s2_r == level_r) begin
        cnt_r <= {CntW{1'b0}};
      end else if (accept_s) begin
        level_r <= s2_r;
        cnt_r   <= {CntW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CntW'(1);
      end
    end
  end

  assign level = level_r;

endmodule

// File: rtl/aux_irq_intake.sv
// Event intake: per-channel debounce, sticky pending flags, priority
// presentation over a valid/ack handshake and a saturating drop counter.
module aux_irq_intake
  import aux_irq_intake_pkg::*;
#(
  parameter int unsigned Channels    = 3,
  parameter int unsigned DebounceCnt = AUX_DEBOUNCE_DEFAULT,
  parameter int unsigned DropCntBit  = 8,
  parameter int unsigned IdBit       = AUX_IRQ_ID_BIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [Channels-1:0]   raw_in,
  input  logic [Channels-1:0]   mask,
  aux_irq_if.master             irq,
  output logic [Channels-1:0]   level,
  output logic [Channels-1:0]   pending,
  output logic [DropCntBit-1:0] drop_cnt
);

  localparam int unsigned WideW = DropCntBit + 4;
  localparam logic [DropCntBit-1:0] DropMax = {DropCntBit{1'b1}};

  logic [Channels-1:0]   rise_s;
  logic [Channels-1:0]   level_s;
  logic [Channels-1:0]   pending_r;
  logic [Channels-1:0]   pending_next_s;
  logic [Channels-1:0]   eligible_s;
  logic [Channels-1:0]   clr_s;
  logic [Channels-1:0]   drop_hit_s;
  logic [3:0]            drop_sum_s;
  logic [WideW-1:0]      drop_wide_s;
  logic [DropCntBit-1:0] drop_next_s;
  logic [DropCntBit-1:0] drop_cnt_r;
  logic                  irq_valid_s;
  logic [IdBit-1:0]      irq_id_s;

  for (genvar g = 0; g < Channels; g++) begin : g_chan
    aux_debounce #(
      .DebounceCnt(DebounceCnt)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_in[g]),
      .level(level_s[g]),
      .rise (rise_s[g])
    );
  end

  // Presentation: lowest-index unmasked pending channel wins.
  always_comb begin
    eligible_s  = pending_r & ~mask;
    irq_valid_s = |eligible_s;
    irq_id_s    = IdBit'(first_set(chan_vec_t'(eligible_s)));
  end

  // Next pending state and number of events lost this cycle.
  always_comb begin
    pending_next_s = pending_r;
    clr_s          = {Channels{1'b0}};
    drop_hit_s     = {Channels{1'b0}};
    drop_sum_s     = 4'd0;
    for (int ch = 0; ch < Channels; ch++) begin
      clr_s[ch]      = irq.ack & irq_valid_s & (irq_id_s == IdBit'(ch));
      drop_hit_s[ch] = rise_s[ch] & pending_r[ch] & ~clr_s[ch];
      drop_sum_s     = drop_sum_s + {3'd0, drop_hit_s[ch]};
      if (rise_s[ch]) begin
        pending_next_s[ch] = 1'b1;
      end else if (clr_s[ch]) begin
        pending_next_s[ch] = 1'b0;
      end else begin
        pending_next_s[ch] = pending_r[ch];
      end
    end
  end

  // Saturating accumulation of dropped events.
  always_comb begin
    drop_wide_s = WideW'(drop_cnt_r) + WideW'(drop_sum_s);
    if (drop_wide_s > WideW'(DropMax)) begin
      drop_next_s = DropMax;
    end else begin
      drop_next_s = drop_wide_s[DropCntBit-1:0];
    end
  end

  // Pending flags and drop counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r  <= {Channels{1'b0}};
      drop_cnt_r <= {DropCntBit{1'b0}};
    end else begin
      pending_r  <= pending_next_s;
      drop_cnt_r <= drop_next_s;
    end
  end

  assign level         = level_s;
  assign pending       = pending_r;
  assign drop_cnt      = drop_cnt_r;
  assign irq.irq_valid = irq_valid_s;
  assign irq.irq_id    = irq_id_s;

endmodule

// File: tb/tb_aux_irq_intake.sv
// Self-checking bench for aux_irq_intake with a window-based reference model.
module tb_aux_irq_intake;

  localparam int CH = 3;
  localparam int DB = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int DMAX = 255;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] mask;
  logic [CH-1:0] level;
  logic [CH-1:0] pending;
  logic [DW-1:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aux_irq_if #(.IdBit(IW)) irq_bus ();

  aux_irq_intake #(
    .Channels(CH), .DebounceCnt(DB), .DropCntBit(DW), .IdBit(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .mask(mask), .irq(irq_bus),
    .level(level), .pending(pending), .drop_cnt(drop_cnt)
  );

  // Reference model: a level flips once the last DB synchronised samples
  // all disagree with it; the window restarts after each flip or reset.
  logic [CH-1:0] m_s1, m_s2, m_level, m_pending;
  int            m_drop;
  bit            m_win [CH][$];

  function automatic bit m_valid();
    return |(m_pending & ~mask);
  endfunction

  function automatic int m_id();
    for (int i = 0; i < CH; i++) if (m_pending[i] && !mask[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    logic [CH-1:0] rise;
    bit vld, clr, all_diff;
    int id, add;
    @(posedge clk);
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pending = '0; m_drop = 0;
      for (int c = 0; c < CH; c++) m_win[c].delete();
    end else begin
      vld = m_valid();
      id = m_id();
      rise = '0;
      for (int c = 0; c < CH; c++) begin
        m_win[c].push_back(m_s2[c]);
        if (m_win[c].size() > DB) void'(m_win[c].pop_front());
        all_diff = (m_win[c].size() == DB);
        foreach (m_win[c][k]) if (m_win[c][k] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = m_s2[c];
          rise[c] = m_s2[c];
          m_win[c].delete();
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_in;
      add = 0;
      for (int c = 0; c < CH; c++) begin
        clr = irq_bus.ack && vld && (id == c);
        if (rise[c]) begin
          if (m_pending[c] && !clr) add++;
          m_pending[c] = 1'b1;
        end else if (clr) begin
          m_pending[c] = 1'b0;
        end
      end
      m_drop = (m_drop + add > DMAX) ? DMAX : m_drop + add;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; raw_in = '0; mask = '0; irq_bus.ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int c);
    raw_in[c] = 1'b1;
    repeat (6) tick();
    raw_in[c] = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; raw_in = 3'b111; mask = '0; irq_bus.ack = 1'b0;
    tick(); tick();
    checks += 5;
    if (level !== 3'b000) begin failures++; $display("FAIL reset_level got=%b want=000", level); end
    if (pending !== 3'b000) begin failures++; $display("FAIL reset_pending got=%b want=000", pending); end
    if (irq_bus.irq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", irq_bus.irq_valid); end
    if (irq_bus.irq_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d want=0", irq_bus.irq_id); end
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (pending !== ((e == 6) ? 3'b111 : 3'b000)) begin
        failures++; $display("FAIL release_pending edge=%0d got=%b", e, pending);
      end
    end
    checks += 2;
    if (irq_bus.irq_id !== 2'd0) begin failures++; $display("FAIL release_id got=%0d want=0", irq_bus.irq_id); end
    if (level !== 3'b111) begin failures++; $display("FAIL release_level got=%b want=111", level); end
    raw_in = '0;
    repeat (6) tick();
    checks++;
    if (level !== 3'b000 || pending !== 3'b111) begin
      failures++; $display("FAIL fall_keeps_pending level=%b pending=%b want 000/111", level, pending);
    end
    irq_bus.ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (pending !== (3'b110 << k)) begin
        failures++; $display("FAIL ack_held step=%0d got=%b want=%b", k, pending, 3'b110 << k);
      end
    end
    irq_bus.ack = 1'b0;
  endtask

  task automatic test_clean_rise();
    do_reset();
    raw_in[1] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (level !== ((e == 6) ? 3'b010 : 3'b000) || pending !== ((e == 6) ? 3'b010 : 3'b000)) begin
        failures++; $display("FAIL rise_latency edge=%0d level=%b pending=%b", e, level, pending);
      end
    end
    checks++;
    if (irq_bus.irq_valid !== 1'b1 || irq_bus.irq_id !== 2'd1) begin
      failures++; $display("FAIL rise_present valid=%b id=%0d want 1/1", irq_bus.irq_valid, irq_bus.irq_id);
    end
    raw_in[1] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (level[1] !== ((e == 6) ? 1'b0 : 1'b1)) begin
        failures++; $display("FAIL fall_latency edge=%0d got=%b", e, level[1]);
      end
    end
    checks++;
    if (pending !== 3'b010) begin failures++; $display("FAIL fall_pending got=%b want=010", pending); end
  endtask

  task automatic test_glitch();
    int rises;
    logic prev;
    do_reset();
    raw_in[2] = 1'b1;
    for (int e = 0; e < 11; e++) begin
      if (e == 3) raw_in[2] = 1'b0;
      tick();
      checks++;
      if (level[2] !== 1'b0 || pending[2] !== 1'b0) begin
        failures++; $display("FAIL glitch edge=%0d level=%b pending=%b", e, level[2], pending[2]);
      end
    end
    rises = 0;
    prev = level[2];
    for (int e = 1; e <= 20; e++) begin
      raw_in[2] = (e == 2) ? 1'b0 : 1'b1;
      tick();
      if (e == 7) begin
        checks++;
        if (level[2] !== 1'b0) begin failures++; $display("FAIL bounce_early got=%b want=0", level[2]); end
      end
      if (e == 8) begin
        checks++;
        if (level[2] !== 1'b1) begin failures++; $display("FAIL bounce_accept got=%b want=1", level[2]); end
      end
      if (!prev && level[2]) rises++;
      prev = level[2];
    end
    checks += 2;
    if (rises != 1) begin failures++; $display("FAIL bounce_events got=%0d want=1", rises); end
    if (pending !== 3'b100 || drop_cnt !== 8'd0) begin
      failures++; $display("FAIL bounce_state pending=%b drop=%0d want 100/0", pending, drop_cnt);
    end
  endtask

  task automatic test_priority();
    do_reset();
    raw_in = 3'b101;
    repeat (6) tick();
    raw_in = 3'b000;
    repeat (6) tick();
    checks++;
    if (pending !== 3'b101 || irq_bus.irq_valid !== 1'b1 || irq_bus.irq_id !== 2'd0) begin
      failures++; $display("FAIL prio_first pending=%b valid=%b id=%0d", pending, irq_bus.irq_valid, irq_bus.irq_id);
    end
    irq_bus.ack = 1'b1; tick(); irq_bus.ack = 1'b0;
    checks++;
    if (pending !== 3'b100 || irq_bus.irq_id !== 2'd2) begin
      failures++; $display("FAIL prio_ack pending=%b id=%0d want 100/2", pending, irq_bus.irq_id);
    end
    mask = 3'b100; tick();
    checks++;
    if (irq_bus.irq_valid !== 1'b0 || irq_bus.irq_id !== 2'd0 || pending !== 3'b100) begin
      failures++; $display("FAIL prio_mask valid=%b id=%0d pending=%b", irq_bus.irq_valid, irq_bus.irq_id, pending);
    end
    irq_bus.ack = 1'b1; tick(); irq_bus.ack = 1'b0; tick();
    checks++;
    if (pending !== 3'b100) begin failures++; $display("FAIL prio_ack_ignored got=%b want=100", pending); end
    mask = 3'b000; tick();
    checks++;
    if (irq_bus.irq_valid !== 1'b1 || irq_bus.irq_id !== 2'd2) begin
      failures++; $display("FAIL prio_unmask valid=%b id=%0d want 1/2", irq_bus.irq_valid, irq_bus.irq_id);
    end
  endtask

  task automatic test_drop();
    do_reset();
    pulse(0);
    checks++;
    if (pending !== 3'b001 || drop_cnt !== 8'd0) begin
      failures++; $display("FAIL drop_first pending=%b drop=%0d want 001/0", pending, drop_cnt);
    end
    pulse(0);
    checks++;
    if (drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_one got=%0d want=1", drop_cnt); end
    repeat (300) pulse(0);
    checks++;
    if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_saturate got=%0d want=255", drop_cnt); end
    pulse(0);
    checks++;
    if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_hold got=%0d want=255", drop_cnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(0);
    raw_in[0] = 1'b1;
    repeat (5) tick();
    irq_bus.ack = 1'b1; tick(); irq_bus.ack = 1'b0;
    checks++;
    if (pending[0] !== 1'b1 || drop_cnt !== 8'd0 || level[0] !== 1'b1) begin
      failures++; $display("FAIL simul_set_wins pending=%b drop=%0d level=%b", pending, drop_cnt, level);
    end
    irq_bus.ack = 1'b1; tick(); irq_bus.ack = 1'b0;
    checks++;
    if (pending[0] !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++; $display("FAIL simul_next_ack pending=%b drop=%0d", pending, drop_cnt);
    end
    raw_in = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 4) == 0) raw_in[c] = ~raw_in[c];
      if ($urandom_range(0, 49) == 0) mask = CH'($urandom_range(0, 7));
      irq_bus.ack = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 699) != 0);
      tick();
      checks++;
      if (level !== m_level || pending !== m_pending || drop_cnt !== DW'(m_drop) ||
          irq_bus.irq_valid !== m_valid() || irq_bus.irq_id !== IW'(m_id())) begin
        failures++;
        $display("FAIL random cyc=%0d level=%b/%b pending=%b/%b drop=%0d/%0d valid=%b/%b id=%0d/%0d",
                 cyc, level, m_level, pending, m_pending, drop_cnt, m_drop,
                 irq_bus.irq_valid, m_valid(), irq_bus.irq_id, m_id());
      end
    end
    rst_n = 1'b1;
    irq_bus.ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; raw_in = '0; mask = '0; irq_bus.ack = 1'b0;
    m_s1 = '0; m_s2 = '0; m_level = '0; m_pending = '0; m_drop = 0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_priority();
    test_drop();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aux_irq_intake.md
Name: aux_irq_intake

Overview:
- Input-side conditioning for the board's external event lines (push buttons / interrupt pins) feeding the core.
- Per channel: 2-FF synchroniser, counter-based debouncer and rising-edge detector. Each detected edge sets a sticky pending flag.
- A valid/ack handshake presents the highest-priority unmasked pending channel to the core. Events lost while a channel is already pending are counted for display.
- Sits between the top-level pins and the core's int inputs; runs on the board clock.

Parameters:
- Channels, 3, number of event lines (1..8).
- DebounceCnt, 1000000, consecutive stable cycles needed to accept a level change (≥1; 10 ms at 100 MHz).
- DropCntBit, 8, width of the saturating dropped-event counter.
- IdBit, 2, width of irq_id; must satisfy 2^IdBit ≥ Channels.

Ports:
- clk  in  1  board clock
- rst_n  in  1  reset; synchronous and active-low
- raw_in  in  Channels  asynchronous raw event lines, active-high
- mask  in  Channels  1 = channel excluded from irq_valid/irq_id (still latches pending)
- ack  in  1  core accepts presented request; single-cycle pulse
- level  out  Channels  debounced stable level per channel
- pending  out  Channels  sticky pending flags
- irq_valid  out  1  some unmasked channel pending
- irq_id  out  IdBit  index of the presented channel
- drop_cnt  out  DropCntBit  count of events lost to an already-pending channel, saturating

Behaviour:
- Reset: all sync FFs, level, debounce counters, pending and drop_cnt go to 0 on a clk edge with rst_n=0. irq_valid=0 and irq_id=0 follow combinationally.
- Reset mid-operation discards all in-flight debounce and pending state. A line held high across reset release produces exactly one event after the full debounce latency.
- Synchroniser: s1<=raw_in, s2<=s1, per bit.
- Debounce, per channel:
  - If s2==level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DebounceCnt-1 while s2!=level, level<=s2 and the counter clears on the same edge.
  - The counter is wide enough for DebounceCnt-1 and never wraps.
- Latency: raw change set up before edge 1 gives a level change at edge 2+DebounceCnt.
- Glitch rule: a pulse that holds for fewer than DebounceCnt sampled cycles at s2 causes no level change.
- Rise: asserts for one cycle when level goes 0→1 on the accepting edge. Falling edges are not events.
- Pending update per channel, evaluated at the same edge as the rise:
  - set = rise.
  - clr = ack && irq_valid && irq_id==ch.
  - If set: pending<=1. Set wins over a simultaneous clr; drop_cnt is unchanged in that case.
  - Else if clr: pending<=0.
  - If set while pending is already 1 and clr is not active: drop_cnt increments, saturating at all-ones.
  - Multiple channels dropping in the same cycle add +1 per channel, still saturating.
- Presentation is combinational from registered state:
  - eligible = pending & ~mask.
  - irq_valid = |eligible.
  - irq_id = lowest index set in eligible (channel 0 highest priority); 0 when none.
- ack with irq_valid=0 is ignored.
- ack held high clears one channel per cycle, following priority.
- Changing mask never alters pending.

Decomposition:
- Auxiliary.vh gains the AUX_DEBOUNCE_DEFAULT constant (CNT_HZ-style macro for 10 ms) and the IRQ id width constant.
- One natural sub-module, aux_debounce: single-channel synchroniser + debounce counter. Outputs are level and a rise pulse; parameter DebounceCnt.
- aux_irq_intake instantiates Channels copies of aux_debounce via generate. It owns pending, priority and drop_cnt logic.

Test Plan (DebounceCnt=4, Channels=3, DropCntBit=8):
1. Reset: hold rst_n=0 for 2 edges with raw_in=3'b111 → level=0, pending=0, irq_valid=0, irq_id=0, drop_cnt=0. After release, one event per channel at edge 6 → pending=3'b111, irq_id=0.
2. Clean rise: raw_in[1] 0→1 before edge 1 and held → level[1]=1 and pending[1]=1 exactly after edge 6 (not 5), irq_valid=1, irq_id=1. Release → level[1]=0 after 6 more edges, pending[1] stays 1.
3. Glitch rejection: raw_in[2] high for 3 cycles, then low → level[2] and pending[2] never change. Bounce 1-0-1 followed by 4 stable cycles → exactly one event.
4. Priority/mask/ack:
   - pending=3'b101, mask=0 → irq_id=0.
   - ack → pending=3'b100, irq_id=2.
   - Set mask[2]=1 → irq_valid=0, pending unchanged.
   - ack in that state → ignored.
5. Drop and saturation: pending[0]=1, second clean event on ch0 → drop_cnt=1. After 300 further unacked events → drop_cnt=255 and holds.
6. Simultaneous: ack for ch0 on the same edge as a new rise on ch0 → pending[0] remains 1, drop_cnt unchanged. Next ack → pending[0]=0.
